// File: rtl/fir_tdm_pkg.sv
// rtl/fir_tdm_pkg.sv - shared widths, FSM encoding and round/saturate helper for fir_tdm_mac
//
// Purpose: width helpers (tap index, channel index, accumulator), default
// parameter values, FSM state type and the output round/saturate function.
// Ports: none (package).

package fir_tdm_pkg;

  localparam int N_DEF    = 10;
  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;
  localparam int NCH_DEF  = 2;
  localparam int FRAC_DEF = 15;

  function automatic int tap_w(input int n);
    return (n + 1 > 1) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int acc_w(input int n, input int dw, input int cw);
    return dw + cw + $clog2(n + 1);
  endfunction

  localparam int TAP_W_DEF = tap_w(N_DEF);
  localparam int CH_W_DEF  = ch_w(NCH_DEF);
  localparam int ACCW_DEF  = acc_w(N_DEF, DW_DEF, CW_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Round half up (add 2^(frac-1), arithmetic shift), then clamp to a
  // dw-bit signed range. Worked in 64 bits so any accumulator width up to
  // 64 passes through unchanged.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_tdm_delay_ram.sv
// rtl/fir_tdm_delay_ram.sv - per-channel circular sample delay lines
//
// Purpose: NCH x (N+1) x DW sample storage with one circular write pointer
// per channel. Writing stores at the channel's pointer and advances it; the
// read port returns the sample k positions older than the newest one.
// Ports:
//   clk, rst            clock, async active-high reset (clears data and pointers)
//   i_we                write strobe (already qualified by the caller)
//   i_wr_ch, i_wr_data  channel and sample for the write
//   i_rd_ch, i_rd_k     channel and tap age for the combinational read
//   o_rd_data           xline[i_rd_ch][(newest - i_rd_k) mod (N+1)]

module fir_tdm_delay_ram
  import fir_tdm_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  localparam int TW  = tap_w(N),
  localparam int CHW = ch_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [CHW-1:0]       i_wr_ch,
  input  logic signed [DW-1:0] i_wr_data,
  input  logic [CHW-1:0]       i_rd_ch,
  input  logic [TW-1:0]        i_rd_k,
  output logic signed [DW-1:0] o_rd_data
);

  localparam logic [TW-1:0] L_NT  = TW'(N);
  localparam logic [TW:0]   L_N   = (TW + 1)'(N);
  localparam logic [TW:0]   L_NP1 = (TW + 1)'(N + 1);

  logic signed [DW-1:0] r_mem [NCH][N+1];
  logic [TW-1:0]        r_ptr [NCH];

  logic [TW-1:0] w_rd_ptr;
  logic [TW:0]   w_sum;
  logic [TW-1:0] w_rd_idx;

  // The pointer sits one past the newest sample, so newest - k is
  // ptr + N - k, folded back once into 0..N.
  assign w_rd_ptr  = r_ptr[i_rd_ch];
  assign w_sum     = {1'b0, w_rd_ptr} + L_N - {1'b0, i_rd_k};
  assign w_rd_idx  = TW'((w_sum > L_N) ? (w_sum - L_NP1) : w_sum);
  assign o_rd_data = r_mem[i_rd_ch][w_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_ptr[c] <= '0;
        for (int t = 0; t <= N; t++) begin
          r_mem[c][t] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_ch][r_ptr[i_wr_ch]] <= i_wr_data;
      r_ptr[i_wr_ch] <= (r_ptr[i_wr_ch] == L_NT) ? '0 : r_ptr[i_wr_ch] + 1'b1;
    end
  end

endmodule

// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - multi-channel time-multiplexed FIR with one shared MAC
//
// Purpose: accepts one sample per handshake, runs N+1 multiply-accumulate
// steps against that channel's delay line, then emits a rounded, saturated
// result tagged with its channel.
// Ports:
//   clk, rst                         clock, async active-high reset
//   i_clk_en                         global enable; low freezes all state
//   i_coef_we/i_coef_addr/i_coef_data  coefficient write (IDLE only)
//   i_in_valid/o_in_ready/i_in_ch/i_x  sample input handshake
//   o_out_valid/o_out_ch/o_y         one-cycle result strobe, channel, value

module fir_tdm_mac
  import fir_tdm_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int NCH  = NCH_DEF,
  parameter int FRAC = FRAC_DEF,
  localparam int TW   = tap_w(N),
  localparam int CHW  = ch_w(NCH),
  localparam int ACCW = acc_w(N, DW, CW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clk_en,
  input  logic                 i_coef_we,
  input  logic [TW-1:0]        i_coef_addr,
  input  logic signed [CW-1:0] i_coef_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [CHW-1:0]       i_in_ch,
  input  logic signed [DW-1:0] i_x,
  output logic                 o_out_valid,
  output logic [CHW-1:0]       o_out_ch,
  output logic signed [DW-1:0] o_y
);

  localparam int PW = DW + CW;
  localparam logic [TW-1:0] L_NT = TW'(N);

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [CHW-1:0]         r_out_ch;
  logic signed [DW-1:0]   r_y;
  logic signed [ACCW-1:0] r_acc;
  logic [TW-1:0]          r_k;
  logic [CHW-1:0]         r_ch;
  logic signed [CW-1:0]   r_coef [N+1];

  logic                 w_accept;
  logic                 w_wr;
  logic                 w_coef_wr;
  logic signed [DW-1:0] w_xd;
  logic signed [CW-1:0] w_tap;
  logic signed [PW-1:0] w_tap_x;
  logic signed [PW-1:0] w_xd_x;
  logic signed [PW-1:0] w_prod;

  // An out-of-range channel still completes the handshake but never
  // reaches the delay lines or the FSM.
  assign w_accept  = i_in_valid & r_in_ready & i_clk_en;
  assign w_wr      = w_accept & (32'(i_in_ch) < NCH);
  assign w_coef_wr = i_clk_en & i_coef_we & (r_state == ST_IDLE) & (32'(i_coef_addr) <= N);

  assign w_tap   = r_coef[r_k];
  assign w_tap_x = PW'(w_tap);
  assign w_xd_x  = PW'(w_xd);
  assign w_prod  = w_tap_x * w_xd_x;

  fir_tdm_delay_ram #(
    .N   (N),
    .DW  (DW),
    .NCH (NCH)
  ) u_delay_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wr),
    .i_wr_ch   (i_in_ch),
    .i_wr_data (i_x),
    .i_rd_ch   (r_ch),
    .i_rd_k    (r_k),
    .o_rd_data (w_xd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_ch        <= '0;
      for (int t = 0; t <= N; t++) begin
        r_coef[t] <= '0;
      end
    end else if (i_clk_en) begin
      // Lands on the accept edge too, so the accepted sample sees it.
      if (w_coef_wr) begin
        r_coef[i_coef_addr] <= i_coef_data;
      end
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (w_wr) begin
            r_acc      <= '0;
            r_k        <= '0;
            r_ch       <= i_in_ch;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_out_valid <= 1'b0;
          r_acc       <= r_acc + ACCW'(w_prod);
          if (r_k == L_NT) begin
            r_state <= ST_OUT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_OUT: begin
          r_y         <= DW'(round_sat(64'(r_acc), FRAC, DW));
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;
  assign o_y         = r_y;

endmodule

// File: tb/tb_fir_tdm_mac.sv
// tb/tb_fir_tdm_mac.sv - directed self-checking bench for fir_tdm_mac

module tb_fir_tdm_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_en;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               in_valid;
  logic               in_ready;
  logic [0:0]         in_ch;
  logic signed [15:0] x;
  logic               out_valid;
  logic [0:0]         out_ch;
  logic signed [15:0] y;

  logic               b_clk_en;
  logic               b_coef_we;
  logic [3:0]         b_coef_addr;
  logic signed [15:0] b_coef_data;
  logic               b_in_valid;
  logic               b_in_ready;
  logic [1:0]         b_in_ch;
  logic signed [15:0] b_x;
  logic               b_out_valid;
  logic [1:0]         b_out_ch;
  logic signed [15:0] b_y;

  int n_vec = 0;
  int n_err = 0;

  int st_at, st_len, cw_at, rst_at;
  logic [3:0]         cw_addr;
  logic signed [15:0] cw_data;
  int got, lat, low, ry, rch;
  int bgot, by, bch;
  int seen;

  int xs_imp[4]  = '{16384, 0, 0, 0};
  int exp_imp[4] = '{0, 0, 16384, 0};

  always #5 clk = ~clk;

  fir_tdm_mac u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_clk_en    (clk_en),
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_data (coef_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_ch     (in_ch),
    .i_x         (x),
    .o_out_valid (out_valid),
    .o_out_ch    (out_ch),
    .o_y         (y)
  );

  fir_tdm_mac #(.NCH(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .i_clk_en    (b_clk_en),
    .i_coef_we   (b_coef_we),
    .i_coef_addr (b_coef_addr),
    .i_coef_data (b_coef_data),
    .i_in_valid  (b_in_valid),
    .o_in_ready  (b_in_ready),
    .i_in_ch     (b_in_ch),
    .i_x         (b_x),
    .o_out_valid (b_out_valid),
    .o_out_ch    (b_out_ch),
    .o_y         (b_y)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a[3:0]; coef_data = d[15:0];
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wrb(input int a, input int d);
    @(negedge clk);
    b_coef_we = 1'b1; b_coef_addr = a[3:0]; b_coef_data = d[15:0];
    @(posedge clk);
    @(negedge clk);
    b_coef_we = 1'b0;
  endtask

  // One sample through the main DUT; per-edge stall / coef write / reset
  // injection controlled by st_at, st_len, cw_at, rst_at.
  task automatic send(input int ch, input int xv);
    got = 0; lat = 0; low = 0; ry = 0; rch = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch[0:0]; x = xv[15:0];
    coef_we = (cw_at == 0); coef_addr = cw_addr; coef_data = cw_data;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    if (!in_ready) low++;
    for (int i = 1; i <= 40; i++) begin
      clk_en  = !(i > st_at && i <= st_at + st_len);
      coef_we = (i == cw_at);
      rst     = (i == rst_at);
      @(posedge clk);
      @(negedge clk);
      clk_en = 1'b1; coef_we = 1'b0; rst = 1'b0;
      if (out_valid) begin
        got = 1; lat = i; ry = y; rch = 32'(out_ch);
        break;
      end
      if (!in_ready) low++;
    end
  endtask

  task automatic sendb(input int ch, input int xv);
    bgot = 0; by = 0; bch = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_ch = ch[1:0]; b_x = xv[15:0];
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_out_valid) begin
        bgot = 1; by = b_y; bch = 32'(b_out_ch);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_ch = '0; x = '0;
    b_clk_en = 1'b1; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    b_in_valid = 1'b0; b_in_ch = '0; b_x = '0;
    st_at = 0; st_len = 0; cw_at = -1; rst_at = -1; cw_addr = '0; cw_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_y", y, 0);

    // impulse response through h[2]
    wr(2, 32767);
    for (int i = 0; i < 4; i++) begin
      send(0, xs_imp[i]);
      chk("imp_got", got, 1);
      chk("imp_y", ry, exp_imp[i]);
      chk("imp_ch", rch, 0);
      chk("imp_lat", lat, 12);
      chk("imp_ready_low", low, 12);
    end
    @(negedge clk);
    chk("out_valid_one_cycle", out_valid, 0);

    // saturation on ch1
    for (int a = 0; a <= 10; a++) wr(a, 32767);
    send(1, 32767);
    chk("sat_first_y", ry, 32766);
    for (int i = 1; i < 11; i++) send(1, 32767);
    chk("sat_pos_y", ry, 32767);
    chk("sat_pos_ch", rch, 1);
    for (int i = 0; i < 11; i++) send(1, -32768);
    chk("sat_neg_y", ry, -32768);

    // channel isolation with h[0]=0.5
    wr(0, 16384);
    for (int a = 1; a <= 10; a++) wr(a, 0);
    for (int i = 0; i < 3; i++) begin
      send(0, 1000);
      chk("iso_ch0_y", ry, 500);
      chk("iso_ch0_ch", rch, 0);
      send(1, 0);
      chk("iso_ch1_y", ry, 0);
      chk("iso_ch1_ch", rch, 1);
    end

    // coefficient write during MAC is dropped, in IDLE with accept is used
    cw_addr = 4'd0; cw_data = 16'sd8192;
    cw_at = 5;
    send(0, 4000);
    chk("coef_mac_ignored", ry, 2000);
    cw_at = 0;
    send(0, 4000);
    chk("coef_idle_used", ry, 1000);
    cw_at = -1;

    // clock-enable stall of 7 cycles mid-MAC
    st_at = 3; st_len = 7;
    send(1, 4000);
    chk("stall_y", ry, 1000);
    chk("stall_lat", lat, 19);
    st_at = 0; st_len = 0;

    // reset at E5 abandons the sample and clears everything
    rst_at = 5;
    send(0, 5000);
    chk("rst_no_out", got, 0);
    rst_at = -1;
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_y", y, 0);
    wr(0, 32767);
    wr(1, 32767);
    send(0, 100);
    chk("post_rst_y", ry, 100);
    chk("post_rst_lat", lat, 12);

    // out-of-range channel on a 3-channel instance
    wrb(0, 32767);
    wrb(1, 32767);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_ch = 2'd3; b_x = 16'sd5000;
    chk("bad_ch_ready", b_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("bad_ch_idle", b_in_ready, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_out_valid) seen++;
    end
    chk("bad_ch_no_out", seen, 0);
    sendb(0, 100);
    chk("b_ch0_y", by, 100);
    chk("b_ch0_ch", bch, 0);
    sendb(1, 200);
    chk("b_ch1_y", by, 200);
    chk("b_ch1_ch", bch, 1);
    sendb(2, 300);
    chk("b_ch2_y", by, 300);
    chk("b_ch2_got", bgot, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
